// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the MIPS execute stage:
//   ALUOP_*  : 2-bit main-control ALU opcode
//   FUNCT_*  : 6-bit R-type funct field values the ALU understands
//   ALUCTL_* : 4-bit decoded ALU control codes
// Optional feature macro used by the top: ALU_OVF_EN (signed overflow flag).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // use funct field
  localparam logic [1:0] ALUOP_OR    = 2'b11;  // ori

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

endpackage

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational ALU-control decoder.
// Ports:
//   alu_op   in  2  main-control ALU opcode
//   funct    in  6  instruction[5:0]
//   alu_ctrl out 4  decoded ALU control
//   illegal  out 1  R-type with a funct the ALU does not implement
// Unsupported R-type functs fall back to add so the datapath stays defined.
// -----------------------------------------------------------------------------
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALUCTL_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALUCTL_ADD;
      ALUOP_SUB: alu_ctrl = ALUCTL_SUB;
      ALUOP_OR:  alu_ctrl = ALUCTL_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALUCTL_ADD;
          FUNCT_SUB: alu_ctrl = ALUCTL_SUB;
          FUNCT_AND: alu_ctrl = ALUCTL_AND;
          FUNCT_OR:  alu_ctrl = ALUCTL_OR;
          FUNCT_NOR: alu_ctrl = ALUCTL_NOR;
          FUNCT_SLT: alu_ctrl = ALUCTL_SLT;
          default: begin
            alu_ctrl = ALUCTL_ADD;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// MIPS single-issue execute stage: ALU-control decode, WIDTH-bit ALU, zero
// detect and branch-taken AND, followed by one output register stage.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   alu_op[1:0]   main-control ALU opcode
//   funct[5:0]    instruction[5:0]
//   a, b          operands (b already muxed with the immediate upstream)
//   branch        Branch flag from control
//   alu_ctrl      registered decoded control
//   result        registered ALU result
//   zero          registered, result == 0
//   branch_taken  registered, branch & zero
//   illegal_op    registered, unsupported R-type funct
//   overflow      registered signed add/sub overflow; constant 0 unless
//                 the ALU_OVF_EN macro is defined
// Interface: no handshake. One op is accepted on every rising edge and its
// outputs are valid from that edge until the next one (latency 1). A reset
// edge overrides the op sampled on that edge and clears every output.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal_op,
  output logic             overflow
);

  logic [3:0]       ctrl_c;
  logic             illegal_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             ovf_c;

  alu_ctrl_dec u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (ctrl_c),
    .illegal  (illegal_c)
  );

  // Modulo 2^WIDTH: carry / borrow out is simply dropped.
  assign sum_c  = a + b;
  assign diff_c = a - b;

  always_comb begin
    result_c = '0;
    case (ctrl_c)
      ALUCTL_AND: result_c = a & b;
      ALUCTL_OR:  result_c = a | b;
      ALUCTL_ADD: result_c = sum_c;
      ALUCTL_SUB: result_c = diff_c;
      ALUCTL_NOR: result_c = ~(a | b);
      ALUCTL_SLT: result_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:    result_c = '0;
    endcase
  end

  // Zero flag covers every op, not just the beq subtract.
  assign zero_c = (result_c == '0);

`ifdef ALU_OVF_EN
  // Two's-complement overflow: operands (b inverted for sub) share a sign
  // that differs from the sign of the wrapped result.
  always_comb begin
    ovf_c = 1'b0;
    case (ctrl_c)
      ALUCTL_ADD: ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      ALUCTL_SUB: ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      default:    ovf_c = 1'b0;
    endcase
  end
`else
  assign ovf_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl     <= 4'b0000;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      alu_ctrl     <= ctrl_c;
      result       <= result_c;
      zero         <= zero_c;
      branch_taken <= branch & zero_c;
      illegal_op   <= illegal_c;
      overflow     <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit. Each driven op pushes its expected
// outputs onto exp_q; one cycle later the registered outputs are popped and
// compared field by field. Overflow expectations follow ALU_OVF_EN.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int QW = 4 + W + 4;  // {ctrl, result, zero, btaken, illegal, ovf}

  logic         clk;
  logic         rst;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         branch;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] result;
  logic         zero;
  logic         branch_taken;
  logic         illegal_op;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  logic [QW-1:0] exp_q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op       (alu_op),
    .funct        (funct),
    .a            (a),
    .b            (b),
    .branch       (branch),
    .alu_ctrl     (alu_ctrl),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op),
    .overflow     (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [QW-1:0] model(input logic r, input logic [1:0] op,
                                          input logic [5:0] f, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic br);
    logic [3:0]   c;
    logic [W-1:0] res;
    logic         ill;
    logic         ov;
    longint       wide;
    c   = 4'b0010;
    ill = 1'b0;
    ov  = 1'b0;
    if (op == 2'b00)      c = 4'b0010;
    else if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11) c = 4'b0001;
    else if (f == 6'h20)  c = 4'b0010;
    else if (f == 6'h22)  c = 4'b0110;
    else if (f == 6'h24)  c = 4'b0000;
    else if (f == 6'h25)  c = 4'b0001;
    else if (f == 6'h27)  c = 4'b1100;
    else if (f == 6'h2A)  c = 4'b0111;
    else ill = 1'b1;
    res = '0;
    wide = 0;
    case (c)
      4'b0000: res = x & y;
      4'b0001: res = x | y;
      4'b1100: res = ~x & ~y;
      4'b0111: res = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
      4'b0010: begin
        wide = longint'($signed(x)) + longint'($signed(y));
        res  = wide[W-1:0];
      end
      4'b0110: begin
        wide = longint'($signed(x)) - longint'($signed(y));
        res  = wide[W-1:0];
      end
      default: res = '0;
    endcase
`ifdef ALU_OVF_EN
    if (c == 4'b0010 || c == 4'b0110)
      ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`endif
    if (r) return '0;
    return {c, res, (res == 0), br && (res == 0), ill, ov};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic compare_out(input string tag);
    logic [QW-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_ctrl"},    {28'd0, alu_ctrl},     {28'd0, e[QW-1 -: 4]});
    check_eq({tag, "_result"},  result,                e[W+3:4]);
    check_eq({tag, "_zero"},    {31'd0, zero},         {31'd0, e[3]});
    check_eq({tag, "_btaken"},  {31'd0, branch_taken}, {31'd0, e[2]});
    check_eq({tag, "_illegal"}, {31'd0, illegal_op},   {31'd0, e[1]});
    check_eq({tag, "_ovf"},     {31'd0, overflow},     {31'd0, e[0]});
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 time unit after the following rising edge.
  task automatic drive(input string tag, input logic r, input logic [1:0] op,
                       input logic [5:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic br);
    rst    = r;
    alu_op = op;
    funct  = f;
    a      = x;
    b      = y;
    branch = br;
    exp_q.push_back(model(r, op, f, x, y, br));
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  // Directed expectations written independently of the model.
  task automatic expect_direct(input string tag, input logic [W-1:0] res, input logic z, input logic ov);
    check_eq({tag, "_dres"},  result,            res);
    check_eq({tag, "_dzero"}, {31'd0, zero},     {31'd0, z});
    check_eq({tag, "_dovf"},  {31'd0, overflow}, {31'd0, ov});
  endtask

  logic [5:0] funct_tbl [8];
  logic       exp_ovf_max;

  initial begin
    funct_tbl[0] = 6'h20; funct_tbl[1] = 6'h22; funct_tbl[2] = 6'h24;
    funct_tbl[3] = 6'h25; funct_tbl[4] = 6'h27; funct_tbl[5] = 6'h2A;
    funct_tbl[6] = 6'h00; funct_tbl[7] = 6'h3F;
`ifdef ALU_OVF_EN
    exp_ovf_max = 1'b1;
`else
    exp_ovf_max = 1'b0;
`endif

    rst = 1'b1; alu_op = 2'b00; funct = 6'h00; a = '0; b = '0; branch = 1'b0;
    @(posedge clk);
    #1;

    // 1. reset for two cycles, then a simple add
    drive("rst0", 1'b1, 2'b10, 6'h00, 32'hFFFF_FFFF, 32'h1, 1'b1);
    drive("rst1", 1'b1, 2'b00, 6'h00, 32'd5, 32'd7, 1'b1);
    expect_direct("rst1", 32'd0, 1'b0, 1'b0);
    check_eq("rst1_dctrl", {28'd0, alu_ctrl}, 32'd0);
    drive("add57", 1'b0, 2'b00, 6'h00, 32'd5, 32'd7, 1'b0);
    expect_direct("add57", 32'd12, 1'b0, 1'b0);
    check_eq("add57_dctrl", {28'd0, alu_ctrl}, 32'h2);

    // 2. beq compare
    drive("beq_t", 1'b0, 2'b01, 6'h00, 32'h1234, 32'h1234, 1'b1);
    check_eq("beq_t_dbt", {31'd0, branch_taken}, 32'd1);
    drive("beq_nb", 1'b0, 2'b01, 6'h00, 32'h1234, 32'h1234, 1'b0);
    check_eq("beq_nb_dbt", {31'd0, branch_taken}, 32'd0);

    // 3. R-type sweep
    drive("r_and", 1'b0, 2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 1'b0);
    expect_direct("r_and", 32'h00F0_F0F0, 1'b0, 1'b0);
    drive("r_or",  1'b0, 2'b10, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 1'b0);
    expect_direct("r_or", 32'hFFF0_FFFF, 1'b0, 1'b0);
    drive("r_nor", 1'b0, 2'b10, 6'h27, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 1'b0);
    expect_direct("r_nor", 32'h000F_0000, 1'b0, 1'b0);
    drive("r_sub", 1'b0, 2'b10, 6'h22, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 1'b0);
    expect_direct("r_sub", 32'hE0FF_F0F1, 1'b0, 1'b0);
    drive("r_slt", 1'b0, 2'b10, 6'h2A, 32'hF0F0_F0F0, 32'h0FF0_FFFF, 1'b0);
    expect_direct("r_slt", 32'd1, 1'b0, 1'b0);

    // 4. slt with positive a, negative b; add wrap to zero
    drive("slt_3m1", 1'b0, 2'b10, 6'h2A, 32'd3, 32'hFFFF_FFFF, 1'b1);
    expect_direct("slt_3m1", 32'd0, 1'b1, 1'b0);
    check_eq("slt_3m1_dbt", {31'd0, branch_taken}, 32'd1);
    drive("add_wrap", 1'b0, 2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 1'b0);
    expect_direct("add_wrap", 32'd0, 1'b1, 1'b0);

    // 5. illegal funct, then a legal op clears the flag
    drive("illegal", 1'b0, 2'b10, 6'h00, 32'd2, 32'd3, 1'b0);
    check_eq("illegal_dflag", {31'd0, illegal_op}, 32'd1);
    check_eq("illegal_dctrl", {28'd0, alu_ctrl}, 32'h2);
    drive("legal", 1'b0, 2'b11, 6'h00, 32'h0F, 32'hF0, 1'b0);
    check_eq("legal_dflag", {31'd0, illegal_op}, 32'd0);
    check_eq("legal_dres", result, 32'hFF);

    // 6. signed overflow boundaries
    drive("ovf_add", 1'b0, 2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    expect_direct("ovf_add", 32'h8000_0000, 1'b0, exp_ovf_max);
    drive("ovf_sub", 1'b0, 2'b01, 6'h00, 32'h8000_0000, 32'd1, 1'b0);
    expect_direct("ovf_sub", 32'h7FFF_FFFF, 1'b0, exp_ovf_max);
    drive("ovf_or", 1'b0, 2'b11, 6'h00, 32'h7FFF_FFFF, 32'd1, 1'b0);
    expect_direct("ovf_or", 32'h7FFF_FFFF, 1'b0, 1'b0);

    // Reset in mid-stream discards the in-flight op
    drive("mid_a", 1'b0, 2'b00, 6'h00, 32'd100, 32'd23, 1'b0);
    drive("mid_rst", 1'b1, 2'b10, 6'h00, 32'd100, 32'd23, 1'b1);
    expect_direct("mid_rst", 32'd0, 1'b0, 1'b0);
    check_eq("mid_rst_dctrl", {28'd0, alu_ctrl}, 32'd0);
    drive("mid_b", 1'b0, 2'b01, 6'h00, 32'd9, 32'd9, 1'b1);

    // Random stream
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      drive("rnd", ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
            funct_tbl[$urandom_range(0, 7)], ra, rb, 1'($urandom_range(0, 1)));
    end

    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
